mc_core_seq: RTL

Multi-cycle sequencer for the RV32 core: the next generation of the single-cycle datapath. It owns the PC, instruction register and inter-stage holding registers and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Instruction and data memories are reached through req/ack handshakes with variable latency, so slow RAMs can be used. Decode, ALU, branch and writeback-mux logic stay combinational outside the block and feed it through the `ex_*` and `wb_*` ports.

---
 rtl/mc_core_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mc_core_seq.sv
// Multi-cycle RV32 sequencer: owns pc/ir/holding registers and walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB with req/ack memory handshakes.
module mc_core_seq #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 255,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [ADDR_W-1:0] ex_next_pc,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              halt_req,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] alu_r,
  output logic [DATA_W-1:0] mdr,
  output logic              rf_we,
  output logic              halted,
  output logic              err,
  output logic [CNT_W-1:0]  instret,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam int              TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] NOP  = DATA_W'(32'h0000_0013);

  state_e              st_q, st_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, npc_q, npc_d;
  logic [DATA_W-1:0]   ir_q, ir_d, alu_q, alu_d, mdr_q, mdr_d, st_r_q, st_r_d;
  logic                ld_q, ld_d, sto_q, sto_d, err_q, err_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                to_hit;

  // Writeback data is consumed by the external register file, not here.
  logic unused_wb;
  assign unused_wb = ^wb_data;

  assign to_hit = (to_q == TO_MAX);

  always_comb begin
    st_d   = st_q;
    pc_d   = pc_q;
    npc_d  = npc_q;
    ir_d   = ir_q;
    alu_d  = alu_q;
    mdr_d  = mdr_q;
    st_r_d = st_r_q;
    ld_d   = ld_q;
    sto_d  = sto_q;
    ret_d  = ret_q;
    to_d   = '0;
    unique case (st_q)
      S_FETCH: begin
        // An ack in the same cycle the wait count hits TIMEOUT still wins.
        if (imem_ack) begin
          ir_d = imem_rdata;
          st_d = S_DECODE;
        end else if (to_hit) begin
          st_d = S_TRAP;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_DECODE: st_d = (ex_is_load && ex_is_store) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        alu_d  = ex_alu_res;
        st_r_d = ex_store_data;
        npc_d  = ex_next_pc;
        ld_d   = ex_is_load;
        sto_d  = ex_is_store;
        st_d   = (ex_is_load || ex_is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (ld_q) mdr_d = dmem_rdata;
          st_d = S_WB;
        end else if (to_hit) begin
          st_d = S_TRAP;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_WB: begin
        pc_d  = npc_q;
        ret_d = ret_q + 1'b1;
        st_d  = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT:  if (!halt_req) st_d = S_FETCH;
      S_TRAP:  st_d = S_TRAP;
      default: st_d = S_TRAP;
    endcase
    err_d = err_q || (st_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_FETCH;
      pc_q   <= RESET_PC;
      npc_q  <= '0;
      ir_q   <= NOP;
      alu_q  <= '0;
      mdr_q  <= '0;
      st_r_q <= '0;
      ld_q   <= 1'b0;
      sto_q  <= 1'b0;
      err_q  <= 1'b0;
      ret_q  <= '0;
      to_q   <= '0;
    end else begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      npc_q  <= npc_d;
      ir_q   <= ir_d;
      alu_q  <= alu_d;
      mdr_q  <= mdr_d;
      st_r_q <= st_r_d;
      ld_q   <= ld_d;
      sto_q  <= sto_d;
      err_q  <= err_d;
      ret_q  <= ret_d;
      to_q   <= to_d;
    end
  end

  // Strobes are gated by rst so a reset cycle never issues or retires anything.
  assign imem_req   = !rst && (st_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = !rst && (st_q == S_MEM);
  assign dmem_we    = sto_q;
  assign dmem_addr  = ADDR_W'(alu_q);
  assign dmem_wdata = st_r_q;
  assign rf_we      = !rst && (st_q == S_WB) && wb_en;
  assign halted     = (st_q == S_HALT);
  assign err        = err_q;
  assign instret    = ret_q;
  assign state      = st_q;
  assign ir         = ir_q;
  assign pc         = pc_q;
  assign alu_r      = alu_q;
  assign mdr        = mdr_q;

endmodule
